// File: rtl/pwm_duty_generator_if.sv
// Control/output bundle for the PWM duty generator: enable, two raw buttons, PWM out.
interface pwm_duty_generator_if;
    logic ena;
    logic ui_increase_duty;
    logic ui_decrease_duty;
    logic uo_PWM_OUT;

    // Controller side: drives enable and buttons, observes the PWM output
    modport master (
        output ena,
        output ui_increase_duty,
        output ui_decrease_duty,
        input  uo_PWM_OUT
    );

    // Generator side
    modport slave (
        input  ena,
        input  ui_increase_duty,
        input  ui_decrease_duty,
        output uo_PWM_OUT
    );
endinterface

// File: rtl/pwm_duty_generator.sv
// Fixed-frequency PWM generator. Duty moves one step per debounced button press,
// saturating at DUTY_MIN/DUTY_MAX; new duty takes effect at the next period start.
module pwm_duty_generator #(
    parameter int unsigned PERIOD    = 10,
    parameter int unsigned DUTY_INIT = 5,
    parameter int unsigned DUTY_MIN  = 1,
    parameter int unsigned DUTY_MAX  = 9,
    parameter int unsigned DEB_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_duty_generator_if.slave  bus
);

    localparam int unsigned CW = $clog2(PERIOD + 1);
    localparam int unsigned DW = $clog2(DEB_DIV);

    localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] DUTY_RST   = CW'(DUTY_INIT);
    localparam logic [CW-1:0] DUTY_LO    = CW'(DUTY_MIN);
    localparam logic [CW-1:0] DUTY_HI    = CW'(DUTY_MAX);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_DIV - 1);

    // Reject parameter sets that would let duty leave the period or break the tick divider
    if (!((DUTY_MIN <= DUTY_INIT) && (DUTY_INIT <= DUTY_MAX) &&
          (DUTY_MAX <= PERIOD) && (DEB_DIV >= 2) && (PERIOD >= 1))) begin : g_param_check
        $error("pwm_duty_generator: illegal parameter combination");
    end

    logic [DW-1:0] deb_cnt_q;
    logic          tick;

    logic          inc_s1_q, inc_s2_q;
    logic          dec_s1_q, dec_s2_q;
    logic          press_inc, press_dec;

    logic [CW-1:0] duty_q,  duty_nxt;
    logic [CW-1:0] dact_q,  dact_nxt;
    logic [CW-1:0] cnt_q,   cnt_nxt;
    logic          pwm_q,   pwm_nxt;

    // Debounce sample tick: one cycle in every DEB_DIV, runs regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
        end
    end

    assign tick = (deb_cnt_q == DEB_LAST);

    // Two-stage button samplers, loaded only on tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_s1_q <= 1'b0;
            inc_s2_q <= 1'b0;
            dec_s1_q <= 1'b0;
            dec_s2_q <= 1'b0;
        end else if (tick) begin
            inc_s1_q <= bus.ui_increase_duty;
            inc_s2_q <= inc_s1_q;
            dec_s1_q <= bus.ui_decrease_duty;
            dec_s2_q <= dec_s1_q;
        end
    end

    // A press is a low-to-high step between consecutive samples; lasts one tick interval
    assign press_inc = inc_s1_q & ~inc_s2_q;
    assign press_dec = dec_s1_q & ~dec_s2_q;

    // Next duty: saturating step on tick while enabled; simultaneous presses cancel
    always_comb begin
        duty_nxt = duty_q;
        if (tick && bus.ena) begin
            case ({press_inc, press_dec})
                2'b10: begin
                    if (duty_q < DUTY_HI) begin
                        duty_nxt = duty_q + CW'(1);
                    end
                end
                2'b01: begin
                    if (duty_q > DUTY_LO) begin
                        duty_nxt = duty_q - CW'(1);
                    end
                end
                default: begin
                    duty_nxt = duty_q;
                end
            endcase
        end
    end

    // Period counter and period-aligned duty latch; counter parks at 0 while disabled
    always_comb begin
        cnt_nxt  = '0;
        dact_nxt = dact_q;
        if (bus.ena) begin
            if (cnt_q == CNT_LAST) begin
                cnt_nxt  = '0;
                dact_nxt = duty_q;
            end else begin
                cnt_nxt  = cnt_q + CW'(1);
            end
        end
    end

    // Output compare, registered one cycle behind the counter
    assign pwm_nxt = bus.ena & (cnt_q < dact_q);

    // Duty, active duty, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= DUTY_RST;
            dact_q <= DUTY_RST;
            cnt_q  <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_nxt;
            dact_q <= dact_nxt;
            cnt_q  <= cnt_nxt;
            pwm_q  <= pwm_nxt;
        end
    end

    assign bus.uo_PWM_OUT = pwm_q;

endmodule

// File: tb/tb_pwm_duty_generator.sv
// Bench for pwm_duty_generator: cycle-by-cycle comparison against a behavioural model,
// directed scenarios with literal duty/high-time expectations, then random button traffic.
module tb_pwm_duty_generator;

    localparam int PERIOD    = 10;
    localparam int DUTY_INIT = 5;
    localparam int DUTY_MIN  = 1;
    localparam int DUTY_MAX  = 9;
    localparam int DEB_DIV   = 4;

    logic clk;
    logic rst_n;

    pwm_duty_generator_if pif ();

    pwm_duty_generator #(
        .PERIOD    (PERIOD),
        .DUTY_INIT (DUTY_INIT),
        .DUTY_MIN  (DUTY_MIN),
        .DUTY_MAX  (DUTY_MAX),
        .DEB_DIV   (DEB_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pif)
    );

    int total;
    int bad;
    bit check_en;

    // Behavioural model state
    int m_cyc;          // clock edges since reset release
    int m_pos;          // position inside the current PWM period
    int m_duty;         // requested duty
    int m_dact;         // duty in force for the current period
    bit m_out;          // expected PWM output
    bit m_inc_last, m_inc_prev;
    bit m_dec_last, m_dec_prev;
    int m_duty_before;
    bit m_tick, m_inc_p, m_dec_p;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: derived from the documented sampling and period rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc      = 0;
            m_pos      = 0;
            m_duty     = DUTY_INIT;
            m_dact     = DUTY_INIT;
            m_out      = 1'b0;
            m_inc_last = 1'b0;
            m_inc_prev = 1'b0;
            m_dec_last = 1'b0;
            m_dec_prev = 1'b0;
        end else begin
            m_duty_before = m_duty;
            m_tick = ((m_cyc % DEB_DIV) == DEB_DIV - 1);
            m_out  = pif.ena && (m_pos < m_dact);
            if (m_tick) begin
                if (pif.ena) begin
                    m_inc_p = m_inc_last && !m_inc_prev;
                    m_dec_p = m_dec_last && !m_dec_prev;
                    if (m_inc_p && !m_dec_p)
                        m_duty = (m_duty + 1 > DUTY_MAX) ? DUTY_MAX : m_duty + 1;
                    else if (m_dec_p && !m_inc_p)
                        m_duty = (m_duty - 1 < DUTY_MIN) ? DUTY_MIN : m_duty - 1;
                end
                m_inc_prev = m_inc_last;
                m_inc_last = pif.ui_increase_duty;
                m_dec_prev = m_dec_last;
                m_dec_last = pif.ui_decrease_duty;
            end
            if (!pif.ena) begin
                m_pos = 0;
            end else if (m_pos == PERIOD - 1) begin
                m_pos  = 0;
                m_dact = m_duty_before;
            end else begin
                m_pos = m_pos + 1;
            end
            m_cyc = m_cyc + 1;
        end
    end

    // Per-cycle output comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            total = total + 1;
            if (pif.uo_PWM_OUT !== m_out) begin
                bad = bad + 1;
                $display("FAIL pwm_out t=%0t cyc=%0d got=%b exp=%b", $time, m_cyc, pif.uo_PWM_OUT, m_out);
            end
        end
    end

    task automatic check_val(input string name, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // High cycles over one full period (duty must be stable)
    task automatic measure_high(output int hi);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pif.uo_PWM_OUT === 1'b1) hi = hi + 1;
        end
    endtask

    task automatic pulse(input bit inc, input bit dec, input int hi_cyc, input int lo_cyc);
        pif.ui_increase_duty = inc;
        pif.ui_decrease_duty = dec;
        wait_cycles(hi_cyc);
        pif.ui_increase_duty = 1'b0;
        pif.ui_decrease_duty = 1'b0;
        wait_cycles(lo_cyc);
    endtask

    task automatic settle_and_check(input string name, input int exp_duty);
        int hi;
        wait_cycles(3 * PERIOD);
        check_val({name, "_model_duty"}, m_duty, exp_duty);
        measure_high(hi);
        check_val({name, "_high_cycles"}, hi, exp_duty);
    endtask

    initial begin
        int hi;
        total    = 0;
        bad      = 0;
        check_en = 1'b0;
        rst_n    = 1'b0;
        pif.ena              = 1'b0;
        pif.ui_increase_duty = 1'b0;
        pif.ui_decrease_duty = 1'b0;

        wait_cycles(3);
        check_val("reset_out", int'(pif.uo_PWM_OUT), 0);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // 1: default 50% duty
        pif.ena = 1'b1;
        settle_and_check("init", 5);

        // 2: three increments
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 10, 10);
        settle_and_check("inc3", 8);

        // 3: three decrements
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 10, 10);
        settle_and_check("dec3", 5);

        // 4: held button gives one step; saturation both ways
        pulse(1'b1, 1'b0, 200, 20);
        settle_and_check("hold", 6);
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 10, 10);
        settle_and_check("sat_hi", 9);
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, 10, 10);
        settle_and_check("sat_lo", 1);

        // 5: both buttons together cancel; mid-period press applies next period
        pulse(1'b1, 1'b1, 20, 10);
        settle_and_check("both", 1);
        wait_cycles(3);
        pulse(1'b1, 1'b0, 10, 10);
        settle_and_check("midper", 2);

        // 6: disabled block ignores presses and holds output low
        pif.ena = 1'b0;
        wait_cycles(2);
        check_val("ena0_out", int'(pif.uo_PWM_OUT), 0);
        pulse(1'b1, 1'b0, 10, 38);
        check_val("ena0_out_late", int'(pif.uo_PWM_OUT), 0);
        check_val("ena0_model_duty", m_duty, 2);
        pif.ena = 1'b1;
        settle_and_check("ena1", 2);

        // Asynchronous reset mid-period: output drops before the next edge
        wait_cycles(1);
        @(negedge clk);
        #1;
        check_val("pre_reset_out", int'(pif.uo_PWM_OUT), 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("async_reset_out", int'(pif.uo_PWM_OUT), 0);
        wait_cycles(3);
        rst_n = 1'b1;
        settle_and_check("post_reset", 5);

        // Random button and enable traffic, checked every cycle by the model
        for (int i = 0; i < 400; i++) begin
            pif.ena              = ($urandom_range(0, 9) != 0);
            pif.ui_increase_duty = ($urandom_range(0, 2) == 0);
            pif.ui_decrease_duty = ($urandom_range(0, 2) == 0);
            wait_cycles($urandom_range(1, 14));
        end
        pif.ui_increase_duty = 1'b0;
        pif.ui_decrease_duty = 1'b0;
        pif.ena = 1'b1;
        wait_cycles(3 * PERIOD);
        measure_high(hi);
        check_val("random_end_high", hi, m_duty);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
